tl_mem_arbiter: RTL and testbench

- N-to-1 TileLink (TL-UH subset, 128-bit beats) arbiter in front of the shared memory slave; a typical requester set is icache fetch and dcache/LSU.
- Grants one upstream master per transaction and locks the grant across all A beats (multi-beat PutFullData) and all D beats (multi-beat AccessAckData).
- Routes D responses back to the owning master, then rotates round-robin priority.
- Sits between the core bus masters and the single-ported memory slave; no buffering of data.

---
 rtl/tl_mem_arbiter_pkg.sv | 17 +
 rtl/tl_mem_arbiter_if.sv | 24 ++
 rtl/tl_mem_arbiter_rr.sv | 18 +
 rtl/tl_mem_arbiter.sv | 103 ++++++++++
 tb/tb_tl_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_mem_arbiter_pkg.sv
// tl_mem_arbiter_pkg: TileLink opcodes, beat geometry, FSM states and beat-count helper shared by the memory arbiter.
package tl_mem_arbiter_pkg;
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
    localparam int BEAT_BYTES = 16;
    localparam int DATA_W     = 128;

    typedef enum logic {IDLE, XFER} state_e;

    // Oversized requests are clamped so a bad size still terminates with a bounded beat count.
    function automatic int beats_of(input logic [7:0] size, input int max_size);
        int s = (int'(size) > max_size) ? max_size : int'(size);
        return (s <= $clog2(BEAT_BYTES)) ? 1 : (1 << (s - $clog2(BEAT_BYTES)));
    endfunction
endpackage

// File: rtl/tl_mem_arbiter_if.sv
// tl_mem_arbiter_if: N-lane TL-UH link (A and D channels), lane i at bit slice [w*i +: w].
// Ports: master drives A fields/valid and D ready; slave drives A ready and D fields/valid.
interface tl_mem_arbiter_if #(parameter int N = 1);
    import tl_mem_arbiter_pkg::*;
    logic [3*N-1:0]          a_opcode, a_param, a_source;
    logic [8*N-1:0]          a_size;
    logic [32*N-1:0]         a_address;
    logic [BEAT_BYTES*N-1:0] a_mask;
    logic [DATA_W*N-1:0]     a_data;
    logic [N-1:0]            a_corrupt, a_valid, a_ready;
    logic [3*N-1:0]          d_opcode, d_source, d_sink;
    logic [2*N-1:0]          d_param;
    logic [8*N-1:0]          d_size;
    logic [DATA_W*N-1:0]     d_data;
    logic [N-1:0]            d_denied, d_corrupt, d_valid, d_ready;
    modport master (
        output a_opcode, a_param, a_source, a_size, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
        input  a_ready, d_opcode, d_source, d_sink, d_param, d_size, d_data, d_denied, d_corrupt, d_valid
    );
    modport slave (
        input  a_opcode, a_param, a_source, a_size, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
        output a_ready, d_opcode, d_source, d_sink, d_param, d_size, d_data, d_denied, d_corrupt, d_valid
    );
endinterface

// File: rtl/tl_mem_arbiter_rr.sv
// tl_mem_arbiter_rr: round-robin pick of the first set request at or after ptr.
// Ports: req (request vector), ptr (highest-priority index), idx (winner index), any (some request set).
module tl_mem_arbiter_rr #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] idx,
    output logic          any
);
    // Walk from the farthest offset down so the closest requester to ptr is written last and wins.
    always_comb begin
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) idx = req[(int'(ptr) + k) % N] ? GW'((int'(ptr) + k) % N) : idx;
    end
endmodule

// File: rtl/tl_mem_arbiter.sv
// tl_mem_arbiter: N-to-1 TL-UH arbiter locking one master across all A and D beats of a transaction.
// Ports: clk, rst (async, active-high); up (N upstream masters, slave side); dn (memory slave, master side);
//        gnt (current owner), busy (transaction in progress), err (sticky: D in idle or oversize request).
module tl_mem_arbiter
    import tl_mem_arbiter_pkg::*;
#(
    parameter int N        = 2,
    parameter int MAX_SIZE = 8,
    localparam int GW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    tl_mem_arbiter_if.slave  up,
    tl_mem_arbiter_if.master dn,
    output logic [GW-1:0]    gnt,
    output logic             busy,
    output logic             err
);
    localparam int CW = ((MAX_SIZE > 4) ? MAX_SIZE - 4 : 0) + 1;

    state_e          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, ptr_q, ptr_d, win;
    logic [CW-1:0]   a_left_q, a_left_d, d_left_q, d_left_d, w_beats;
    logic            err_q, err_d, any, xfer, a_open, d_open, a_hs, d_hs;
    logic [N-1:0]    own;
    logic [2:0]      w_op;
    logic [7:0]      w_size;
    int              gi, wi;

    tl_mem_arbiter_rr #(.N(N), .GW(GW)) u_rr (.req(up.a_valid), .ptr(ptr_q), .idx(win), .any(any));

    always_comb begin
        gi = int'(gnt_q);
        wi = int'(win);
        xfer = state_q == XFER;
        own = N'(1) << gnt_q;
        a_open = xfer && a_left_q != '0;
        d_open = xfer && d_left_q != '0;
        dn.a_opcode = up.a_opcode[3*gi +: 3];
        dn.a_param = up.a_param[3*gi +: 3];
        dn.a_source = up.a_source[3*gi +: 3];
        dn.a_size = up.a_size[8*gi +: 8];
        dn.a_address = up.a_address[32*gi +: 32];
        dn.a_mask = up.a_mask[BEAT_BYTES*gi +: BEAT_BYTES];
        dn.a_data = up.a_data[DATA_W*gi +: DATA_W];
        dn.a_corrupt = up.a_corrupt[gi];
        dn.a_valid = a_open && up.a_valid[gi];
        up.a_ready = (a_open && dn.a_ready[0]) ? own : '0;
        // D stays open during the A phase so a Put ack may coincide with the last A beat.
        up.d_valid = (d_open && dn.d_valid[0]) ? own : '0;
        dn.d_ready = d_open && up.d_ready[gi];
        up.d_opcode = {N{dn.d_opcode}};
        up.d_source = {N{dn.d_source}};
        up.d_sink = {N{dn.d_sink}};
        up.d_param = {N{dn.d_param}};
        up.d_size = {N{dn.d_size}};
        up.d_data = {N{dn.d_data}};
        up.d_denied = {N{dn.d_denied}};
        up.d_corrupt = {N{dn.d_corrupt}};
        a_hs = dn.a_valid[0] && dn.a_ready[0];
        d_hs = dn.d_valid[0] && dn.d_ready[0];
        w_op = up.a_opcode[3*wi +: 3];
        w_size = up.a_size[8*wi +: 8];
        w_beats = CW'(beats_of(w_size, MAX_SIZE));
        state_d = state_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        a_left_d = a_left_q - CW'(a_hs);
        d_left_d = d_left_q - CW'(d_hs);
        err_d = err_q | (!xfer && dn.d_valid[0]) | (!xfer && any && int'(w_size) > MAX_SIZE);
        if (!xfer && any) begin
            state_d = XFER;
            gnt_d = win;
            a_left_d = (w_op == PUT_FULL) ? w_beats : CW'(1);
            d_left_d = (w_op == GET) ? w_beats : CW'(1);
        end else if (xfer && a_left_d == '0 && d_left_d == '0) begin
            state_d = IDLE;
            ptr_d = (gnt_q == GW'(N - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            ptr_q <= '0;
            a_left_q <= '0;
            d_left_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            a_left_q <= a_left_d;
            d_left_q <= d_left_d;
            err_q <= err_d;
        end
    end

    assign gnt = gnt_q;
    assign busy = state_q == XFER;
    assign err = err_q;
endmodule

// File: tb/tb_tl_mem_arbiter.sv
// tb_tl_mem_arbiter: random and directed traffic checked against a transaction-level arbiter model.
module tb_tl_mem_arbiter;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:0] gnt;
    logic busy, err;
    always #5 clk = ~clk;

    tl_mem_arbiter_if #(.N(N)) up();
    tl_mem_arbiter_if #(.N(1)) dn();
    tl_mem_arbiter #(.N(N), .MAX_SIZE(8)) dut (.clk(clk), .rst(rst), .up(up), .dn(dn), .gnt(gnt), .busy(busy), .err(err));

    int unsigned p_sar = 100, p_sdv = 100, p_dr = 100, p_req = 0;
    bit auto_d = 1, sd_man = 0, sat = 0;
    int a_left_m[N], d_exp_m[N], rx_cnt[N];
    int owe, put_cnt, sa_cnt;
    int m_own, m_a, m_d, m_ptr, m_gnt, w, w_size;
    bit m_err, e_ahs, e_dhs, sa_hs, sd_hs, prev_busy;
    bit ahs_m[N], dhs_m[N];
    logic [2:0] w_op, sa_op;
    logic [7:0] sa_size;
    int gseq[$];
    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbeats(input int size);
        int s = (size > 8) ? 8 : size;
        return (s <= 4) ? 1 : 2 ** (s - 4);
    endfunction

    task automatic issue(input int i, input int op, input int size, input logic [31:0] addr);
        up.a_opcode[3*i +: 3] = 3'(op);
        up.a_param[3*i +: 3] = 3'd0;
        up.a_source[3*i +: 3] = 3'(i);
        up.a_size[8*i +: 8] = 8'(size);
        up.a_address[32*i +: 32] = addr;
        up.a_mask[16*i +: 16] = 16'hffff;
        up.a_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
        up.a_corrupt[i] = 1'b0;
        a_left_m[i] = (op == 0) ? nbeats(size) : 1;
        d_exp_m[i] = (op == 4) ? nbeats(size) : 1;
    endtask

    function automatic bit quiet();
        bit q = m_own < 0 && owe == 0;
        for (int i = 0; i < N; i++) q &= a_left_m[i] == 0 && d_exp_m[i] == 0;
        return q;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (p_req > 0 && a_left_m[i] == 0 && d_exp_m[i] == 0 && $urandom_range(0, 99) < p_req) begin
                int r = $urandom_range(0, 2);
                if (sat) issue(i, 4, 4, 32'h8000_0000 + 32'(i * 4096));
                else issue(i, (r == 0) ? 0 : (r == 1) ? 4 : 1, $urandom_range(0, 6), $urandom);
            end
            up.a_valid[i] = a_left_m[i] > 0;
            up.d_ready[i] = $urandom_range(0, 99) < p_dr;
        end
        dn.a_ready[0] = $urandom_range(0, 99) < p_sar;
        dn.d_opcode = auto_d ? 3'd1 : 3'd0;
        dn.d_param = 2'd0;
        dn.d_source = 3'($urandom);
        dn.d_sink = 3'd0;
        dn.d_size = 8'($urandom);
        dn.d_data = {$urandom, $urandom, $urandom, $urandom};
        dn.d_denied = 1'b0;
        dn.d_corrupt = 1'b0;
        dn.d_valid[0] = auto_d ? (owe > 0 && $urandom_range(0, 99) < p_sdv) : sd_man;
    endtask

    task automatic observe();
        bit idle = m_own < 0;
        logic [N-1:0] e_ar = '0, e_dv = '0;
        bit e_sav = 0, e_sdr = 0;
        if (!idle) begin
            e_sav = m_a > 0 && up.a_valid[m_own];
            e_ar[m_own] = m_a > 0 && dn.a_ready[0];
            e_dv[m_own] = m_d > 0 && dn.d_valid[0];
            e_sdr = m_d > 0 && up.d_ready[m_own];
        end
        chk("busy", busy, !idle);
        chk("gnt", gnt, m_gnt);
        chk("m_a_ready", up.a_ready, e_ar);
        chk("m_d_valid", up.d_valid, e_dv);
        chk("s_a_valid", dn.a_valid, e_sav);
        chk("s_d_ready", dn.d_ready, e_sdr);
        chk("err", err, m_err);
        if (e_sav) chk("s_a_address", dn.a_address, up.a_address[32*m_own +: 32]);
        if (e_dv != 0) chk("m_d_data", up.d_data[128*m_own +: 64], dn.d_data[63:0]);
        e_ahs = e_sav && dn.a_ready[0];
        e_dhs = e_sdr && dn.d_valid[0];
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && up.a_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
            w_op = up.a_opcode[3*w +: 3];
            w_size = int'(up.a_size[8*w +: 8]);
        end
        for (int i = 0; i < N; i++) begin
            ahs_m[i] = up.a_valid[i] && up.a_ready[i];
            dhs_m[i] = up.d_valid[i] && up.d_ready[i];
        end
        sa_hs = dn.a_valid[0] && dn.a_ready[0];
        sd_hs = dn.d_valid[0] && dn.d_ready[0];
        sa_op = dn.a_opcode;
        sa_size = dn.a_size;
        if (busy && !prev_busy) gseq.push_back(int'(gnt));
        prev_busy = busy;
    endtask

    task automatic update();
        if (m_own < 0) begin
            m_err |= dn.d_valid[0] || (w >= 0 && w_size > 8);
            if (w >= 0) begin
                m_own = w;
                m_gnt = w;
                m_a = (w_op == 3'd0) ? nbeats(w_size) : 1;
                m_d = (w_op == 3'd4) ? nbeats(w_size) : 1;
            end
        end else begin
            m_a -= int'(e_ahs);
            m_d -= int'(e_dhs);
            if (m_a == 0 && m_d == 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ahs_m[i]) a_left_m[i]--;
            if (dhs_m[i]) begin
                d_exp_m[i]--;
                rx_cnt[i]++;
            end
        end
        if (sa_hs) begin
            sa_cnt++;
            if (auto_d) begin
                if (sa_op == 3'd4) owe += nbeats(int'(sa_size));
                else if (sa_op == 3'd0) begin
                    put_cnt++;
                    if (put_cnt == nbeats(int'(sa_size))) begin
                        owe++;
                        put_cnt = 0;
                    end
                end else owe++;
            end
        end
        if (sd_hs && auto_d) owe--;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1 observe();
        @(posedge clk);
        update();
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while (c < maxc && !quiet()) begin
            step();
            c++;
        end
        chk("drain_in_budget", c < maxc, 1);
    endtask

    task automatic model_reset();
        m_own = -1; m_a = 0; m_d = 0; m_ptr = 0; m_gnt = 0; m_err = 0;
        owe = 0; put_cnt = 0; prev_busy = 0;
        for (int i = 0; i < N; i++) begin
            a_left_m[i] = 0;
            d_exp_m[i] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int rx0, rx1, sa0, g0;
        up.a_opcode = '0; up.a_param = '0; up.a_source = '0; up.a_size = '0; up.a_address = '0;
        up.a_mask = '0; up.a_data = '0; up.a_corrupt = '0; up.a_valid = '0; up.d_ready = '0;
        dn.a_ready = '0; dn.d_valid = '0; dn.d_opcode = '0; dn.d_param = '0; dn.d_source = '0;
        dn.d_sink = '0; dn.d_size = '0; dn.d_data = '0; dn.d_denied = '0; dn.d_corrupt = '0;
        sa_cnt = 0;
        for (int i = 0; i < N; i++) rx_cnt[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_err", err, 0);
        chk("rst_handshakes", {up.a_ready, up.d_valid, dn.a_valid, dn.d_ready}, 0);
        @(negedge clk) rst = 1'b0;

        rx0 = rx_cnt[0]; sa0 = sa_cnt;
        issue(0, 4, 6, 32'h8000_0000);
        drain(100);
        chk("get_d_beats_m0", rx_cnt[0] - rx0, 4);
        chk("get_a_beats", sa_cnt - sa0, 1);
        chk("get_d_beats_m1", rx_cnt[1], 0);

        auto_d = 0; sd_man = 0; rx1 = rx_cnt[1]; sa0 = sa_cnt;
        issue(1, 0, 6, 32'h8000_1000);
        repeat (4) step();
        sd_man = 1;
        step();
        sd_man = 0;
        step();
        chk("put_a_beats", sa_cnt - sa0, 4);
        chk("put_ack_m1", rx_cnt[1] - rx1, 1);
        chk("put_idle_after", busy, 0);
        auto_d = 1;

        g0 = gseq.size();
        issue(0, 4, 4, 32'h8000_0100);
        issue(1, 4, 4, 32'h8000_0200);
        drain(100);
        chk("both_grants", gseq.size() - g0, 2);
        if (gseq.size() >= g0 + 2) begin
            chk("both_first", gseq[g0], 0);
            chk("both_second", gseq[g0+1], 1);
        end

        g0 = gseq.size(); rx0 = rx_cnt[0]; rx1 = rx_cnt[1];
        sat = 1; p_req = 100;
        for (int c = 0; c < 1000 && gseq.size() < g0 + 20; c++) step();
        sat = 0; p_req = 0;
        drain(200);
        chk("sat_grants", gseq.size() >= g0 + 20, 1);
        for (int k = 0; k < 20 && g0 + k < gseq.size(); k++) chk("sat_alternate", gseq[g0+k], k % 2);
        chk("sat_m0_served", rx_cnt[0] - rx0 >= 9, 1);
        chk("sat_m1_served", rx_cnt[1] - rx1 >= 9, 1);

        p_req = 30; p_sar = 60; p_sdv = 60; p_dr = 70;
        repeat (400) step();
        p_req = 0;
        drain(2000);
        p_sar = 100; p_sdv = 100; p_dr = 100;

        auto_d = 0; sd_man = 1;
        step();
        sd_man = 0;
        repeat (3) step();
        chk("err_spurious_sticky", err, 1);
        auto_d = 1;

        issue(0, 0, 6, 32'h8000_2000);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_handshakes", {up.a_ready, up.d_valid, dn.a_valid, dn.d_ready}, 0);
        model_reset();
        up.a_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        g0 = gseq.size();
        issue(0, 4, 4, 32'h8000_3000);
        issue(1, 4, 4, 32'h8000_4000);
        drain(100);
        if (gseq.size() > g0) chk("post_rst_first_gnt", gseq[g0], 0);
        else chk("post_rst_grants", gseq.size() - g0, 2);

        rx0 = rx_cnt[0];
        issue(0, 4, 9, 32'h8000_5000);
        drain(200);
        chk("oversize_d_beats", rx_cnt[0] - rx0, 16);
        chk("oversize_err", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
